// File: rtl/irq_dispatch4_if.sv
// Bus between the four-line interrupt dispatcher and its requester/consumer.
// Grant handshake: irq_id is stable whenever irq_valid=1, and the grant is consumed
// on a clock edge where irq_valid=1 and irq_ack=1. irq_ack is ignored while irq_valid=0.
interface irq_dispatch4_if;
  logic [3:0] req;
  logic [3:0] mask;
  logic       irq_ack;
  logic       ovf_clr;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] overflow;

  modport master (
    output req, mask, irq_ack, ovf_clr,
    input  irq_valid, irq_id, pending, overflow
  );

  modport slave (
    input  req, mask, irq_ack, ovf_clr,
    output irq_valid, irq_id, pending, overflow
  );
endinterface

// File: rtl/irq_dispatch4.sv
// Four-line interrupt latch and dispatcher: requests become pending events, and the
// highest-priority enabled pending line (bit 3 first) is presented one at a time.
module irq_dispatch4 #(
  parameter bit EDGE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  irq_dispatch4_if.slave bus,
  output logic           dbg_state
);
  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t     state;
  logic [3:0] req_q;
  logic [3:0] evt;
  logic [3:0] ack_clr;
  logic [3:0] ovf_set;
  logic [3:0] cand;
  logic [1:0] win_id;

  always_comb begin
    evt     = EDGE ? (bus.req & ~req_q) : bus.req;
    ack_clr = 4'b0000;
    if (bus.irq_valid && bus.irq_ack) ack_clr[bus.irq_id] = 1'b1;
    // An event landing on a line being acked on the same edge is a re-arm, not an overflow.
    ovf_set = EDGE ? (evt & bus.pending & ~ack_clr) : 4'b0000;
    cand    = bus.pending & bus.mask;
    win_id  = 2'd0;
    for (int n = 0; n < 4; n++) begin
      if (cand[n]) win_id = n[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q        <= 4'b0000;
      bus.pending  <= 4'b0000;
      bus.overflow <= 4'b0000;
    end else begin
      req_q        <= bus.req;
      bus.pending  <= (bus.pending & ~ack_clr) | evt;
      bus.overflow <= (bus.ovf_clr ? 4'b0000 : bus.overflow) | ovf_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.irq_valid <= 1'b0;
      bus.irq_id    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cand != 4'b0000) begin
            bus.irq_id    <= win_id;
            bus.irq_valid <= 1'b1;
            state         <= PRESENT;
          end
        end
        PRESENT: begin
          // No preemption and no revocation on mask change: only ack ends a grant.
          if (bus.irq_ack) begin
            bus.irq_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.irq_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = (state == PRESENT);
endmodule

// File: tb/tb_irq_dispatch4.sv
// Bench for irq_dispatch4: an edge-mode and a level-mode instance checked by directed
// vector tables, hand sequences and randomized traffic against a per-line reference model.
module tb_irq_dispatch4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  irq_dispatch4_if bus_e ();
  irq_dispatch4_if bus_l ();
  logic dbg_e, dbg_l;

  irq_dispatch4 #(.EDGE(1'b1)) u_edge (.clk(clk), .rst(rst), .bus(bus_e), .dbg_state(dbg_e));
  irq_dispatch4 #(.EDGE(1'b0)) u_lvl  (.clk(clk), .rst(rst), .bus(bus_l), .dbg_state(dbg_l));

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       oc;
    logic       ev;
    logic [1:0] eid;
    logic [3:0] ep;
    logic [3:0] eo;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, index 0 = edge instance, 1 = level instance.
  logic [3:0] m_req_q[2];
  logic [3:0] m_pend[2];
  logic [3:0] m_ovf[2];
  logic       m_valid[2];
  logic [1:0] m_id[2];
  logic       prev_valid[2];
  logic [1:0] exp_q_e[$];
  logic [1:0] exp_q_l[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_req_q[m]    = 4'b0000;
      m_pend[m]     = 4'b0000;
      m_ovf[m]      = 4'b0000;
      m_valid[m]    = 1'b0;
      m_id[m]       = 2'b00;
      prev_valid[m] = 1'b0;
    end
    exp_q_e.delete();
    exp_q_l.delete();
  endtask

  task automatic model_step(int m, logic [3:0] r, logic [3:0] mk, logic ak, logic oc);
    logic [3:0] pend_before;
    bit fired;
    bit served;
    pend_before = m_pend[m];
    if (oc) m_ovf[m] = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      fired  = (m == 0) ? (r[n] && !m_req_q[m][n]) : r[n];
      served = m_valid[m] && ak && (int'(m_id[m]) == n);
      if (fired && m == 0 && pend_before[n] && !served) m_ovf[m][n] = 1'b1;
      if (fired) m_pend[m][n] = 1'b1;
      else if (served) m_pend[m][n] = 1'b0;
    end
    m_req_q[m] = r;
    if (m_valid[m]) begin
      if (ak) m_valid[m] = 1'b0;
    end else begin
      for (int n = 3; n >= 0; n--) begin
        if (pend_before[n] && mk[n]) begin
          m_valid[m] = 1'b1;
          m_id[m]    = n[1:0];
          if (m == 0) exp_q_e.push_back(n[1:0]);
          else        exp_q_l.push_back(n[1:0]);
          break;
        end
      end
    end
  endtask

  task automatic compare_one(int m, logic v, logic [1:0] id, logic [3:0] p, logic [3:0] o, logic d);
    string tag;
    logic [1:0] want;
    bit have;
    tag = (m == 0) ? "edge" : "lvl";
    check({tag, " valid"}, 8'(v), 8'(m_valid[m]));
    check({tag, " dbg_state"}, 8'(d), 8'(m_valid[m]));
    check({tag, " pending"}, 8'(p), 8'(m_pend[m]));
    check({tag, " overflow"}, 8'(o), 8'(m_ovf[m]));
    if (m_valid[m]) check({tag, " irq_id"}, 8'(id), 8'(m_id[m]));
    if (v === 1'b1 && prev_valid[m] !== 1'b1) begin
      have = 1'b1;
      want = 2'b00;
      if (m == 0) begin
        if (exp_q_e.size() == 0) have = 1'b0; else want = exp_q_e.pop_front();
      end else begin
        if (exp_q_l.size() == 0) have = 1'b0; else want = exp_q_l.pop_front();
      end
      if (have) check({tag, " grant"}, 8'(id), 8'(want));
      else begin
        n_tests++;
        n_fail++;
        $display("FAIL %s grant: got id %0d expected no grant", tag, id);
      end
    end
    prev_valid[m] = v;
  endtask

  task automatic drive(int m, logic [3:0] r, logic [3:0] mk, logic ak, logic oc);
    if (m == 0) begin
      bus_e.req = r; bus_e.mask = mk; bus_e.irq_ack = ak; bus_e.ovf_clr = oc;
    end else begin
      bus_l.req = r; bus_l.mask = mk; bus_l.irq_ack = ak; bus_l.ovf_clr = oc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, bus_e.req, bus_e.mask, bus_e.irq_ack, bus_e.ovf_clr);
    model_step(1, bus_l.req, bus_l.mask, bus_l.irq_ack, bus_l.ovf_clr);
    #1;
    compare_one(0, bus_e.irq_valid, bus_e.irq_id, bus_e.pending, bus_e.overflow, dbg_e);
    compare_one(1, bus_l.irq_valid, bus_l.irq_id, bus_l.pending, bus_l.overflow, dbg_l);
  endtask

  task automatic check_zero(string tag, logic v, logic [1:0] id, logic [3:0] p, logic [3:0] o);
    check({tag, " rst valid"}, 8'(v), 8'h00);
    check({tag, " rst irq_id"}, 8'(id), 8'h00);
    check({tag, " rst pending"}, 8'(p), 8'h00);
    check({tag, " rst overflow"}, 8'(o), 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero("edge", bus_e.irq_valid, bus_e.irq_id, bus_e.pending, bus_e.overflow);
    check_zero("lvl", bus_l.irq_valid, bus_l.irq_id, bus_l.pending, bus_l.overflow);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic add_vec(logic [3:0] r, logic [3:0] mk, logic ak, logic oc,
                         logic ev, logic [1:0] eid, logic [3:0] ep, logic [3:0] eo);
    vec_t v;
    v.req = r; v.mask = mk; v.ack = ak; v.oc = oc;
    v.ev = ev; v.eid = eid; v.ep = ep; v.eo = eo;
    vecs.push_back(v);
  endtask

  initial begin
    // Directed table for the edge instance: inputs before an edge, outputs after it.
    add_vec(4'b0100, 4'hF, 0, 0, 0, 2'd0, 4'b0100, 4'b0000);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 4'b0000);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd2, 4'b0100, 4'b0000);
    add_vec(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 4'b0000);
    add_vec(4'b0011, 4'hF, 0, 0, 0, 2'd0, 4'b0011, 4'b0000);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd1, 4'b0011, 4'b0000);
    add_vec(4'b1000, 4'hF, 0, 0, 1, 2'd1, 4'b1011, 4'b0000);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd1, 4'b1011, 4'b0000);
    add_vec(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b1001, 4'b0000);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd3, 4'b1001, 4'b0000);
    add_vec(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b0001, 4'b0000);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd0, 4'b0001, 4'b0000);
    add_vec(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 4'b0000);
    add_vec(4'b1001, 4'h7, 0, 0, 0, 2'd0, 4'b1001, 4'b0000);
    add_vec(4'b0000, 4'h7, 0, 0, 1, 2'd0, 4'b1001, 4'b0000);
    add_vec(4'b0000, 4'h7, 1, 0, 0, 2'd0, 4'b1000, 4'b0000);
    add_vec(4'b0000, 4'h7, 0, 0, 0, 2'd0, 4'b1000, 4'b0000);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd3, 4'b1000, 4'b0000);
    add_vec(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 4'b0000);
    add_vec(4'b0010, 4'hF, 0, 0, 0, 2'd0, 4'b0010, 4'b0000);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd1, 4'b0010, 4'b0000);
    add_vec(4'b0010, 4'hF, 0, 0, 1, 2'd1, 4'b0010, 4'b0010);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd1, 4'b0010, 4'b0010);
    add_vec(4'b0010, 4'hF, 1, 0, 0, 2'd0, 4'b0010, 4'b0010);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd1, 4'b0010, 4'b0010);
    add_vec(4'b0000, 4'hF, 0, 1, 1, 2'd1, 4'b0010, 4'b0000);
    add_vec(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 4'b0000);
    add_vec(4'b0010, 4'hF, 0, 0, 0, 2'd0, 4'b0010, 4'b0000);
    add_vec(4'b0000, 4'hF, 0, 0, 1, 2'd1, 4'b0010, 4'b0000);
    add_vec(4'b0010, 4'hF, 0, 1, 1, 2'd1, 4'b0010, 4'b0010);
    add_vec(4'b0000, 4'hF, 0, 1, 1, 2'd1, 4'b0010, 4'b0000);
    add_vec(4'b0000, 4'hF, 1, 0, 0, 2'd0, 4'b0000, 4'b0000);

    drive(0, 4'b0000, 4'hF, 1'b0, 1'b0);
    drive(1, 4'b0000, 4'hF, 1'b0, 1'b0);
    #1;
    do_reset();

    foreach (vecs[i]) begin
      drive(0, vecs[i].req, vecs[i].mask, vecs[i].ack, vecs[i].oc);
      drive(1, 4'b0000, 4'hF, 1'b0, 1'b0);
      tick();
      check($sformatf("vec%0d valid", i), 8'(bus_e.irq_valid), 8'(vecs[i].ev));
      check($sformatf("vec%0d pending", i), 8'(bus_e.pending), 8'(vecs[i].ep));
      check($sformatf("vec%0d overflow", i), 8'(bus_e.overflow), 8'(vecs[i].eo));
      if (vecs[i].ev) check($sformatf("vec%0d irq_id", i), 8'(bus_e.irq_id), 8'(vecs[i].eid));
    end

    // Level mode: a held line is redispatched every 2 cycles and never overflows.
    drive(0, 4'b0000, 4'hF, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive(1, 4'b0100, 4'hF, (k > 0 && k % 2 == 0), 1'b0);
      tick();
      check($sformatf("lvl hold%0d valid", k), 8'(bus_l.irq_valid), 8'(k % 2));
      check($sformatf("lvl hold%0d pending", k), 8'(bus_l.pending), 8'h04);
      check($sformatf("lvl hold%0d overflow", k), 8'(bus_l.overflow), 8'h00);
      if (k % 2 == 1) check($sformatf("lvl hold%0d irq_id", k), 8'(bus_l.irq_id), 8'h02);
    end
    drive(1, 4'b0000, 4'hF, 1'b1, 1'b0);
    tick();
    check("lvl release pending", 8'(bus_l.pending), 8'h00);

    // Reset while a grant is presented and two lines are pending.
    drive(1, 4'b0000, 4'hF, 1'b0, 1'b0);
    drive(0, 4'b1010, 4'hF, 1'b0, 1'b0);
    tick();
    drive(0, 4'b0000, 4'hF, 1'b0, 1'b0);
    tick();
    check("pre-rst valid", 8'(bus_e.irq_valid), 8'h01);
    check("pre-rst pending", 8'(bus_e.pending), 8'h0A);
    drive(0, 4'b0001, 4'hF, 1'b0, 1'b0);
    drive(1, 4'b0001, 4'hF, 1'b0, 1'b0);
    do_reset();
    tick();
    check("post-rst edge pending", 8'(bus_e.pending), 8'h01);
    check("post-rst lvl pending", 8'(bus_l.pending), 8'h01);
    drive(0, 4'b0000, 4'hF, 1'b0, 1'b0);
    drive(1, 4'b0000, 4'hF, 1'b0, 1'b0);
    tick();

    // Randomized traffic on both instances against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < 2; m++) begin
        logic [3:0] r;
        logic [3:0] mk;
        logic ak;
        mk = (m == 0) ? bus_e.mask : bus_l.mask;
        if ($urandom_range(0, 15) == 0) mk = 4'($urandom_range(0, 15));
        r  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        ak = m_valid[m] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
        drive(m, r, mk, ak, ($urandom_range(0, 15) == 0));
      end
      tick();
    end

    // Drain outstanding grants, then every predicted grant must have been observed.
    for (int c = 0; c < 40; c++) begin
      drive(0, 4'b0000, 4'hF, m_valid[0], 1'b0);
      drive(1, 4'b0000, 4'hF, m_valid[1], 1'b0);
      tick();
    end
    check("edge grants left", 8'(exp_q_e.size()), 8'h00);
    check("lvl grants left", 8'(exp_q_l.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_dispatch4.md
# irq_dispatch4

Four-line interrupt request latch and dispatcher that sits directly upstream of the 4-to-2 priority encoder stage. It registers raw request lines, holds them as pending events, and presents one winning index at a time to the consumer with a valid/ack handshake. The priority order matches the encoder: bit 3 is highest and bit 0 is lowest. Requests that lose arbitration are not lost; they stay pending until they are served.

## Interface
- EDGE, default 1: 1 = rising-edge-triggered requests; 0 = level-triggered requests.
- clk, input, 1: the single clock. All state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset. It clears all state immediately.
- req, input, 4: raw request lines. They are synchronous to clk.
- mask, input, 4: 1 = line enabled for dispatch. Masked lines still latch pending.
- irq_ack, input, 1: consumer accepts the presented index. Sampled only when irq_valid = 1.
- ovf_clr, input, 1: synchronous clear of all overflow bits.
- irq_valid, output, 1: irq_id holds a dispatched request.
- irq_id, output, 2: index of the dispatched request. Encoding: 3 → 2'b11, 2 → 2'b10, 1 → 2'b01, 0 → 2'b00.
- pending, output, 4: latched, not-yet-acknowledged requests.
- overflow, output, 4: sticky per-line flag. Set when a new event hits a line that is already pending.

## Operation
- **Request sampling**
  - req_q is a 4-bit register that copies req every cycle. It resets to 0.
  - event = req & ~req_q when EDGE = 1.
  - event = req when EDGE = 0.
- **Pending register**
  - pending[n] is set on an edge where event[n] = 1.
  - pending[n] is cleared on an edge where irq_ack & irq_valid & (irq_id == n).
  - If set and clear hit the same bit on the same edge, set wins and pending[n] stays 1.
- **Overflow**
  - EDGE = 1: overflow[n] is set when event[n] = 1 and pending[n] = 1 before the edge, unless the same edge clears that bit through ack.
  - EDGE = 0: overflow is never set.
  - ovf_clr clears all overflow bits. If ovf_clr and a set coincide, set wins.
- **FSM** (two states, IDLE and PRESENT)
  - IDLE:
    - cand = pending & mask, using registered values.
    - If cand != 0: load irq_id with the index of the highest set bit of cand, set irq_valid = 1, go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT:
    - irq_id and irq_valid hold stable.
    - There is no preemption: a newly pending higher-priority line does not change irq_id.
    - Clearing mask[irq_id] does not revoke the grant.
    - On irq_ack = 1: irq_valid drops to 0, pending[irq_id] clears (subject to set-wins), return to IDLE.
  - irq_ack while in IDLE is ignored.
- **Reset values:** irq_valid = 0, irq_id = 2'b00, pending = 4'b0000, overflow = 4'b0000, req_q = 0, FSM = IDLE.
- **Reset behaviour**
  - Reset mid-handshake drops irq_valid asynchronously and discards all pending events.
  - Because req_q resets to 0, a req line held high through reset counts as an event on the first edge after release, in both modes.

## Timing
- Request to pending:
  - req[n] is high before edge E0 (with req_q[n] = 0 in edge mode).
  - pending[n] = 1 after E0.
- Pending to dispatch: irq_valid = 1 and irq_id valid after E1. Dispatch latency is 2 edges from request sampling.
- Ack:
  - irq_ack is high before edge Ea.
  - irq_valid = 0 and pending bit clear after Ea.
  - The next dispatch is no earlier than Ea+1.
- Maximum throughput: one dispatch per 2 cycles.
- Outputs are registered. There is no combinational path from any input to any output.

## Test plan
- **Single request, edge mode, mask = 4'b1111**
  - Stimulus: pulse req = 4'b0100 for 1 cycle.
  - Required: pending = 4'b0100 after E0; irq_valid = 1 with irq_id = 2'b10 after E1.
  - Stimulus: ack at E3.
  - Required: irq_valid = 0 and pending = 0 after E3.
- **Priority and no preemption**
  - Stimulus: req = 4'b0011 pulsed, then req[3] pulsed while PRESENT.
  - Required: irq_id = 2'b01 held until ack. The next grants are 2'b11 then 2'b00, each 1 cycle after the preceding ack.
- **Masking**
  - Stimulus: mask = 4'b0111, req = 4'b1001 pulsed.
  - Required: pending = 4'b1001; only 2'b00 is dispatched. After ack, irq_valid stays 0 with pending = 4'b1000.
  - Stimulus: set mask = 4'b1111.
  - Required: 2'b11 is dispatched 1 edge later.
- **Overflow and set-wins**
  - Stimulus: pulse req[1] twice before ack.
  - Required: overflow = 4'b0010.
  - Stimulus: pulse req[1] on the same edge as its ack.
  - Required: pending[1] stays 1, overflow unchanged, redispatch follows.
  - Stimulus: ovf_clr.
  - Required: overflow = 0.
- **Level mode (EDGE = 0)**
  - Stimulus: hold req[2] = 1.
  - Required: after each ack, pending[2] stays 1 and 2'b10 is redispatched every 2 cycles; overflow stays 0.
- **Reset mid-operation**
  - Stimulus: assert rst while irq_valid = 1 and pending = 4'b1010.
  - Required: irq_valid, irq_id, pending and overflow go to 0 immediately.
  - Stimulus: release rst with req[0] held high.
  - Required: pending = 4'b0001 after the first edge.
